mem_access_arbiter: RTL
=======================

// Module: mem_access_arbiter
// PURPOSE
// - Shares the single memory bus between instruction fetch and data accesses (read_mem/write_mem/load_byte/store_byte from the control logic unit).
// - Sequences each transaction over a registered request/busy bus; returns the result to the winning requester with a one-cycle ack.
// - Drives the core stall. Sits between fetch/execute stages and the memory bus interface.
// PARAMETERS
// - ADDR_W          32   byte address width
// - DATA_W          32   bus data width (fixed 32; 4 byte lanes)
// - TIMEOUT_CYCLES  255  bus wait limit; used only with MEM_ARB_TIMEOUT_EN
// PORTS
// - clk            in   1       system clock, rising edge
// - nrst           in   1       asynchronous active-low reset
// - if_req         in   1       fetch request, held until if_ack
// - if_addr        in   ADDR_W  fetch address (word aligned)
// - if_rdata       out  DATA_W  fetched word, valid with if_ack
// - if_ack         out  1       one-cycle fetch completion pulse
// - d_read_mem     in   1       data load request, held until d_ack
// - d_write_mem    in   1       data store request, held until d_ack
// - d_load_byte    in   1       load is byte-wide (else word)
// - d_store_byte   in   1       store is byte-wide (else word)
// - d_addr         in   ADDR_W  data byte address
// - d_wdata        in   DATA_W  store data (byte in [7:0] for byte stores)
// - d_rdata        out  DATA_W  load result, valid with d_ack
// - d_ack          out  1       one-cycle data completion pulse
// - bus_addr       out  ADDR_W  bus address, low 2 bits forced to 0
// - bus_wdata      out  DATA_W  bus write data
// - bus_sel        out  4       byte-lane enables
// - bus_read       out  1       one-cycle read strobe
// - bus_write      out  1       one-cycle write strobe
// - bus_rdata      in   DATA_W  bus read data, valid when bus_busy low
// - bus_busy       in   1       transaction in progress
// - stall          out  1       (if_req & ~if_ack) | (data req & ~d_ack), combinational
// - timeout_err    out  1       sticky bus-timeout flag (MEM_ARB_TIMEOUT_EN only)
// BEHAVIOUR
// - Reset (async, any state): state IDLE; all outputs 0; last_grant = DATA; in-flight transaction abandoned, no ack.
// - FSM states IDLE, FETCH, DREAD, DWRITE; all bus_* and ack outputs registered.
// - IDLE, cycle N: select requester, latch addr/data/sel, assert strobe, go to state. Strobe is high in N+1 only.
// - FETCH/DREAD/DWRITE: bus_busy sampled from cycle N+2. First edge with bus_busy=0: capture bus_rdata, pulse ack in next cycle, return to IDLE. Minimum req->ack latency 3 cycles.
// - Priority: data wins when only last_grant=FETCH. With both pending and last_grant=DATA, fetch wins (alternating; no starvation).
// - During a requester's ack cycle, that requester's req is ignored (no re-issue of a held request).
// - d_read_mem & d_write_mem both high: treated as write; d_ack covers both.
// - Word store: sel=4'hF, wdata=d_wdata. Byte store: sel=1<<d_addr[1:0], wdata={4{d_wdata[7:0]}}.
// - Word load: d_rdata=bus_rdata. Byte load: lane d_addr[1:0], zero-extended; sign extension is done downstream.
// - Fetches always use sel=4'hF, bus_read.
// - Requests dropped before ack: transaction still completes on the bus; ack pulses and is ignored.
// CONFIGURATION
// - MEM_ARB_TIMEOUT_EN defined: 8-bit wait counter runs in the wait states. At TIMEOUT_CYCLES with bus_busy still high: abort, ack the requester with rdata=0, set timeout_err (sticky until nrst).
// - MEM_ARB_TIMEOUT_EN undefined: waits on bus_busy indefinitely; no counter; timeout_err port absent.
// STRUCTURE
// - mem_arb_pkg: arb_state_t enum {IDLE, FETCH, DREAD, DWRITE}, grant_t {GRANT_FETCH, GRANT_DATA}, SEL_WORD=4'hF.
// - Sub-module byte_lane_unit (combinational): sel/wdata replication for stores and rdata lane extraction for loads.
// - Top module holds FSM, arbitration, registers, stall.
// TESTING
// - Fetch only: if_addr=0x100, bus_busy low, bus_rdata=0x00000013 -> bus_read in N+1 only, if_ack in N+3, if_rdata=0x13.
// - Byte store d_addr=0x203, d_wdata=0xAB -> bus_addr=0x200, bus_sel=4'b1000, bus_wdata=0xABABABAB, d_ack once.
// - Byte load d_addr=0x201, bus_rdata=0x11223344 -> d_rdata=0x00000033. Word load -> 0x11223344.
// - if_req & d_read_mem held together, last_grant=DATA -> fetch is served first, then data. No double issue; stall low after second ack.
// - bus_busy held 5 cycles -> ack 5 cycles later than minimum. nrst pulsed mid-wait -> outputs 0, IDLE, no ack.
// - With MEM_ARB_TIMEOUT_EN, bus_busy stuck high -> ack at 255 cycles with rdata=0, timeout_err=1 until reset.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Purpose: shared types and constants for the memory access arbiter.
//   arb_state_t : arbiter FSM states
//   grant_t     : last requester served, used for alternating priority
//   ld_desc_t   : pending load descriptor (byte/word, lane) kept for result extraction
//   lane_sel()  : one-hot byte-lane enable for a byte access
package mem_arb_pkg;

    localparam int unsigned SEL_W  = 4;
    localparam int unsigned LANE_W = 2;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned BYTE_W = 8;

    localparam logic [SEL_W-1:0] SEL_WORD = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DREAD  = 2'd2,
        DWRITE = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

    typedef struct packed {
        logic              byte_op;
        logic [LANE_W-1:0] lane;
    } ld_desc_t;

    function automatic logic [SEL_W-1:0] lane_sel(input logic [LANE_W-1:0] lane);
        return SEL_W'(1) << lane;
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Purpose: combinational byte-lane steering between the 32-bit bus and the data port.
//   sel_byte/sel_lane -> sel_c   : byte-lane enables (one lane for byte ops, all lanes otherwise)
//   st_wdata          -> wdata_c : store data, low byte replicated on all lanes for byte stores
//   ld_byte/ld_lane/ld_rdata -> rdata_c : load result, selected lane zero-extended for byte loads
module byte_lane_unit
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              sel_byte,
    input  logic [LANE_W-1:0] sel_lane,
    input  logic [DATA_W-1:0] st_wdata,
    input  logic              ld_byte,
    input  logic [LANE_W-1:0] ld_lane,
    input  logic [DATA_W-1:0] ld_rdata,
    output logic [SEL_W-1:0]  sel_c,
    output logic [DATA_W-1:0] wdata_c,
    output logic [DATA_W-1:0] rdata_c
);

    // Lane enables and store data replication
    always_comb begin
        sel_c   = SEL_WORD;
        wdata_c = st_wdata;
        if (sel_byte) begin
            sel_c   = lane_sel(sel_lane);
            wdata_c = DATA_W'({SEL_W{st_wdata[BYTE_W-1:0]}});
        end
    end

    // Load lane extraction; sign extension happens downstream
    always_comb begin
        rdata_c = ld_rdata;
        if (ld_byte) begin
            rdata_c = DATA_W'(ld_rdata[{ld_lane, 3'b000} +: BYTE_W]);
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Purpose: shares one memory bus between instruction fetch and data accesses,
// sequences each transaction over a registered strobe/busy handshake and returns
// the result to the winner with a one-cycle ack. Drives the core stall.
// Ports:
//   clk, nrst                     clock, async active-low reset
//   if_req/if_addr -> if_rdata/if_ack        fetch port
//   d_read_mem/d_write_mem/d_load_byte/d_store_byte/d_addr/d_wdata
//                  -> d_rdata/d_ack          data port
//   bus_addr/bus_wdata/bus_sel/bus_read/bus_write, bus_rdata/bus_busy   memory bus
//   stall                         combinational core stall
//   timeout_err                   sticky bus timeout flag (only with MEM_ARB_TIMEOUT_EN)
// Build option: define MEM_ARB_TIMEOUT_EN to abort bus waits after TIMEOUT_CYCLES.
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_read_mem,
    input  logic              d_write_mem,
    input  logic              d_load_byte,
    input  logic              d_store_byte,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [SEL_W-1:0]  bus_sel,
    output logic              bus_read,
    output logic              bus_write,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_busy,
    output logic              stall
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    arb_state_t        state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    ld_desc_t          ld_q, ld_d;
    logic              armed_q, armed_d;
    logic [ADDR_W-1:0] bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_d;
    logic [SEL_W-1:0]  bus_sel_d;
    logic              bus_read_d, bus_write_d;
    logic [DATA_W-1:0] if_rdata_d, d_rdata_d;
    logic              if_ack_d, d_ack_d;
    logic              done, abort;

    logic              fetch_pend, data_pend, sel_byte;
    logic [SEL_W-1:0]  sel_c;
    logic [DATA_W-1:0] wdata_c, ld_rdata_c;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_err_d;
    logic              unused_cfg;
    assign unused_cfg = ^if_addr[1:0];
`else
    logic              unused_cfg;
    assign unused_cfg = ^{if_addr[1:0], 32'(TIMEOUT_CYCLES)};
`endif

    // A requester's held request is masked during its own ack cycle
    assign fetch_pend = if_req & ~if_ack;
    assign data_pend  = (d_read_mem | d_write_mem) & ~d_ack;
    assign stall      = fetch_pend | data_pend;

    assign sel_byte = d_write_mem ? d_store_byte : d_load_byte;

    byte_lane_unit #(
        .DATA_W (DATA_W)
    ) u_lanes (
        .sel_byte (sel_byte),
        .sel_lane (d_addr[LANE_W-1:0]),
        .st_wdata (d_wdata),
        .ld_byte  (ld_q.byte_op),
        .ld_lane  (ld_q.lane),
        .ld_rdata (bus_rdata),
        .sel_c    (sel_c),
        .wdata_c  (wdata_c),
        .rdata_c  (ld_rdata_c)
    );

    // Next state, arbitration and next values of all registered outputs
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        ld_d         = ld_q;
        armed_d      = armed_q;
        bus_addr_d   = bus_addr;
        bus_wdata_d  = bus_wdata;
        bus_sel_d    = bus_sel;
        bus_read_d   = 1'b0;
        bus_write_d  = 1'b0;
        if_rdata_d   = if_rdata;
        d_rdata_d    = d_rdata;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        done         = 1'b0;
        abort        = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err;
`endif

        case (state_q)
            IDLE: begin
                // Fetch wins on contention only if data was served last
                if (fetch_pend && (!data_pend || last_grant_q == GRANT_DATA)) begin
                    state_d      = FETCH;
                    last_grant_d = GRANT_FETCH;
                    armed_d      = 1'b0;
                    bus_addr_d   = {if_addr[ADDR_W-1:LANE_W], LANE_W'(0)};
                    bus_sel_d    = SEL_WORD;
                    bus_read_d   = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end else if (data_pend) begin
                    last_grant_d = GRANT_DATA;
                    armed_d      = 1'b0;
                    bus_addr_d   = {d_addr[ADDR_W-1:LANE_W], LANE_W'(0)};
                    bus_sel_d    = sel_c;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                    // Read and write together is treated as a write
                    if (d_write_mem) begin
                        state_d     = DWRITE;
                        bus_wdata_d = wdata_c;
                        bus_write_d = 1'b1;
                    end else begin
                        state_d     = DREAD;
                        bus_read_d  = 1'b1;
                        ld_d        = '{byte_op: d_load_byte, lane: d_addr[LANE_W-1:0]};
                    end
                end
            end
            default: begin
                // Busy is not valid yet in the strobe cycle; start sampling one cycle later
                if (!armed_q) begin
                    armed_d = 1'b1;
                end else if (!bus_busy) begin
                    done = 1'b1;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    done          = 1'b1;
                    abort         = 1'b1;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
        endcase

        // Completion: return result to whoever owns the transaction
        if (done) begin
            state_d = IDLE;
            if (state_q == FETCH) begin
                if_ack_d   = 1'b1;
                if_rdata_d = abort ? '0 : bus_rdata;
            end else begin
                d_ack_d = 1'b1;
                if (state_q == DREAD) begin
                    d_rdata_d = abort ? '0 : ld_rdata_c;
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_DATA;
            ld_q         <= '0;
            armed_q      <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            bus_sel      <= '0;
            bus_read     <= 1'b0;
            bus_write    <= 1'b0;
            if_rdata     <= '0;
            d_rdata      <= '0;
            if_ack       <= 1'b0;
            d_ack        <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            timeout_err  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            ld_q         <= ld_d;
            armed_q      <= armed_d;
            bus_addr     <= bus_addr_d;
            bus_wdata    <= bus_wdata_d;
            bus_sel      <= bus_sel_d;
            bus_read     <= bus_read_d;
            bus_write    <= bus_write_d;
            if_rdata     <= if_rdata_d;
            d_rdata      <= d_rdata_d;
            if_ack       <= if_ack_d;
            d_ack        <= d_ack_d;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            timeout_err  <= timeout_err_d;
`endif
        end
    end

endmodule
